// File: rtl/reflet_int_to_float_seq.sv
// Integer (signed/unsigned) to binary32 converter, normalising one bit per cycle, round-to-nearest-even.
// Latency: out_valid rises lz+2 edges after the accept edge (lz = leading zeros of the magnitude).
// Backpressure: one conversion in flight; in_ready only in IDLE, result held in OUT until out_ready.
module reflet_int_to_float_seq #(
    parameter int INT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT_WIDTH-1:0] int_in,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          float_out,
    output logic                 inexact
);

    localparam int W     = INT_WIDTH;
    localparam int EXT_W = W + 23;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               sign;
    logic [W-1:0]       mag;
    logic [7:0]         e;
    logic               norm_done;
    logic               neg_in;
    logic [EXT_W-1:0]   ext;
    logic [22:0]        frac;
    logic               g;
    logic               s;
    logic               rnd_up;
    logic [23:0]        frac_sum;
    logic [7:0]         e_fin;

    assign norm_done = (mag == '0) || mag[W-1];
    assign neg_in    = is_signed & int_in[W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = NORM;
            NORM:    if (norm_done) state_nxt = ROUND;
            ROUND:                  state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    // Hidden bit dropped; padding on the right covers widths narrower than the fraction.
    always_comb begin
        ext      = {mag[W-2:0], 24'd0};
        frac     = ext[EXT_W-1 -: 23];
        g        = ext[EXT_W-24];
        s        = |ext[EXT_W-25:0];
        rnd_up   = g & (s | frac[0]);
        frac_sum = {1'b0, frac} + {23'd0, rnd_up};
        e_fin    = e + 8'd127 + {7'd0, frac_sum[23]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            float_out <= 32'd0;
            inexact   <= 1'b0;
            sign      <= 1'b0;
            mag       <= '0;
            e         <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= neg_in;
                        mag  <= neg_in ? -int_in : int_in;
                        e    <= 8'(W - 1);
                    end
                end
                NORM: begin
                    if (!norm_done) begin
                        mag <= mag << 1;
                        e   <= e - 8'd1;
                    end
                end
                ROUND: begin
                    if (mag == '0) begin
                        float_out <= 32'd0;
                        inexact   <= 1'b0;
                    end else begin
                        float_out <= {sign, e_fin, (frac_sum[23] ? 23'd0 : frac_sum[22:0])};
                        inexact   <= g | s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_int_to_float_seq.sv
// Bench for reflet_int_to_float_seq: 16-bit and 32-bit instances checked against an arithmetic reference.
module tb_reflet_int_to_float_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [63:0] iin       [2];
    logic        sgn_in    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] fo        [2];
    logic        inex      [2];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    bit chk_on   = 1'b0;

    bit          pend      [2];
    bit          seen      [2];
    int          acc_edge  [2];
    int          exp_lz    [2];
    logic [31:0] exp_f     [2];
    bit          exp_i     [2];
    logic [31:0] last_f    [2];
    bit          last_i    [2];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    reflet_int_to_float_seq #(.INT_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .int_in(iin[0][15:0]), .is_signed(sgn_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .float_out(fo[0]), .inexact(inex[0])
    );

    reflet_int_to_float_seq #(.INT_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .int_in(iin[1][31:0]), .is_signed(sgn_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .float_out(fo[1]), .inexact(inex[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Reference: exact magnitude, highest set bit, then round the discarded tail by value.
    function automatic void model(input logic [63:0] raw, input int w, input bit sgn,
                                  output logic [31:0] f, output bit ix, output int lz);
        logic [63:0] v, mag, keep, rem, half;
        bit neg;
        int p, sh;
        v    = raw & ((64'd1 << w) - 64'd1);
        neg  = sgn && v[w-1];
        mag  = neg ? ((64'd1 << w) - v) : v;
        f    = 32'd0;
        ix   = 1'b0;
        lz   = 0;
        if (mag == 64'd0) return;
        p = 63;
        while (!mag[p]) p--;
        lz = w - 1 - p;
        if (p <= 23) begin
            keep = mag << (23 - p);
        end else begin
            sh   = p - 23;
            keep = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            ix   = (rem != 64'd0);
            if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
            if (keep[24]) begin
                keep = keep >> 1;
                p    = p + 1;
            end
        end
        f = {neg, 8'(p + 127), keep[22:0]};
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    pend[k]   = 1'b0;
                    last_f[k] = 32'd0;
                    last_i[k] = 1'b0;
                end else begin
                    chk($sformatf("in_ready_%0d", k), 64'(in_ready[k]), 64'(!pend[k]));
                    if (!pend[k]) chk($sformatf("idle_out_valid_%0d", k), 64'(out_valid[k]), 64'd0);
                    if (!out_valid[k]) begin
                        chk($sformatf("held_float_%0d", k), 64'(fo[k]), 64'(last_f[k]));
                        chk($sformatf("held_inexact_%0d", k), 64'(inex[k]), 64'(last_i[k]));
                    end else if (pend[k]) begin
                        if (!seen[k]) begin
                            seen[k] = 1'b1;
                            chk($sformatf("latency_%0d", k), 64'(edge_cnt - acc_edge[k]), 64'(exp_lz[k] + 2));
                        end
                        chk($sformatf("float_out_%0d", k), 64'(fo[k]), 64'(exp_f[k]));
                        chk($sformatf("inexact_%0d", k), 64'(inex[k]), 64'(exp_i[k]));
                        if (out_ready[k]) begin
                            last_f[k] = fo[k];
                            last_i[k] = inex[k];
                            pend[k]   = 1'b0;
                        end
                    end
                    if (in_valid[k] && in_ready[k]) begin
                        model(iin[k], (k == 0) ? 16 : 32, sgn_in[k], exp_f[k], exp_i[k], exp_lz[k]);
                        pend[k]     = 1'b1;
                        seen[k]     = 1'b0;
                        acc_edge[k] = edge_cnt + 1;
                    end
                end
            end
        end
    end

    task automatic convert(input int k, input logic [63:0] v, input bit sgn, input int hold);
        int n;
        logic [31:0] held;
        @(posedge clk); #1;
        iin[k] = v; sgn_in[k] = sgn; in_valid[k] = 1'b1; out_ready[k] = 1'b0;
        n = 0;
        while (!in_ready[k] && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin fail_now("accept"); in_valid[k] = 1'b0; return; end
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        iin[k] = {$urandom, $urandom};
        sgn_in[k] = 1'($urandom);
        n = 0;
        while (!out_valid[k] && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin fail_now("out_valid"); return; end
        held = fo[k];
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_stable", 64'(fo[k]), 64'(held));
            chk("hold_in_ready", 64'(in_ready[k]), 64'd0);
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
    endtask

    task automatic conv_chk(input string name, input int k, input logic [63:0] v, input bit sgn,
                            input int hold, input logic [31:0] ef, input bit ei);
        convert(k, v, sgn, hold);
        chk({name, "_f"}, 64'(last_f[k]), 64'(ef));
        chk({name, "_x"}, 64'(last_i[k]), 64'(ei));
    endtask

    initial begin
        logic [31:0] mf;
        bit          mi;
        int          ml;
        logic [63:0] rv;
        int          w, bits, k;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; iin[i] = 64'd0; sgn_in[i] = 1'b0;
            pend[i] = 1'b0; seen[i] = 1'b0; last_f[i] = 32'd0; last_i[i] = 1'b0;
            acc_edge[i] = 0; exp_lz[i] = 0; exp_f[i] = 32'd0; exp_i[i] = 1'b0;
        end

        @(posedge clk); #1;
        chk("rst_in_ready16", 64'(in_ready[0]), 64'd1);
        chk("rst_in_ready32", 64'(in_ready[1]), 64'd1);
        @(posedge clk); #1;
        chk("rst_out_valid16", 64'(out_valid[0]), 64'd0);
        chk("rst_out_valid32", 64'(out_valid[1]), 64'd0);
        chk("rst_float16", 64'(fo[0]), 64'd0);
        chk("rst_float32", 64'(fo[1]), 64'd0);
        chk("rst_inexact16", 64'(inex[0]), 64'd0);
        chk("rst_inexact32", 64'(inex[1]), 64'd0);
        reset = 1'b0;
        chk_on = 1'b1;

        // Pin the reference against hand-worked values.
        model(64'hFFFA, 16, 1'b1, mf, mi, ml);
        chk("model_m6_f", 64'(mf), 64'hC0C00000);
        chk("model_m6_lz", 64'(ml), 64'd13);
        model(64'hFFFFFFFF, 32, 1'b0, mf, mi, ml);
        chk("model_umax_f", 64'(mf), 64'h4F800000);
        chk("model_umax_x", 64'(mi), 64'd1);
        model(64'd16777219, 32, 1'b1, mf, mi, ml);
        chk("model_tie_f", 64'(mf), 64'h4B800002);
        model(64'h80000000, 32, 1'b1, mf, mi, ml);
        chk("model_min_f", 64'(mf), 64'hCF000000);

        conv_chk("t1_m6",      0, 64'hFFFA, 1'b1, 0, 32'hC0C00000, 1'b0);
        conv_chk("t2_134",     0, 64'd134,  1'b1, 1, 32'h43060000, 1'b0);
        conv_chk("t2_m3457",   0, 64'hF27F, 1'b1, 0, 32'hC5581000, 1'b0);
        conv_chk("t2_m1",      0, 64'hFFFF, 1'b1, 2, 32'hBF800000, 1'b0);
        conv_chk("t2_p1",      0, 64'd1,    1'b1, 0, 32'h3F800000, 1'b0);
        conv_chk("t2_zero",    0, 64'd0,    1'b1, 0, 32'h00000000, 1'b0);
        conv_chk("t3_max",     1, 64'h7FFFFFFF, 1'b1, 0, 32'h4F000000, 1'b1);
        conv_chk("t3_min",     1, 64'h80000000, 1'b1, 0, 32'hCF000000, 1'b0);
        conv_chk("t4_umax",    1, 64'hFFFFFFFF, 1'b0, 0, 32'h4F800000, 1'b1);
        conv_chk("t5_tie_dn",  1, 64'd16777217, 1'b1, 0, 32'h4B800000, 1'b1);
        conv_chk("t5_tie_up",  1, 64'd16777219, 1'b0, 0, 32'h4B800002, 1'b1);
        conv_chk("t6_hold",    1, 64'd1000,     1'b0, 5, 32'h447A0000, 1'b0);

        // Abort a long normalisation with a reset pulse.
        @(posedge clk); #1;
        iin[1] = 64'd1; sgn_in[1] = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_busy", 64'(in_ready[1]), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_in_ready", 64'(in_ready[1]), 64'd1);
        chk("abort_out_valid", 64'(out_valid[1]), 64'd0);
        chk("abort_float", 64'(fo[1]), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        conv_chk("after_abort", 1, 64'd5, 1'b0, 0, 32'h40A00000, 1'b0);

        for (int i = 0; i < 160; i++) begin
            k    = i % 2;
            w    = (k == 0) ? 16 : 32;
            bits = $urandom_range(0, w);
            if (bits == 0) begin
                rv = 64'd0;
            end else begin
                rv = {$urandom, $urandom};
                rv = rv >> (64 - bits);
            end
            convert(k, rv, 1'($urandom), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
